// File: rtl/temp_poll_seq.sv
// Command sequencer for the fan-board temperature sensor: configures it once, then polls MSB/LSB.
// Optional transaction watchdog, error counter and sensor_ok clearing are enabled by TEMP_POLL_WDOG_EN.
module temp_poll_seq #(
  parameter logic [6:0] DEV_ADDR       = 7'h48,
  parameter logic [7:0] CFG_REG        = 8'h01,
  parameter logic [7:0] CFG_DATA       = 8'h60,
  parameter logic [7:0] MSB_REG        = 8'h00,
  parameter logic [7:0] LSB_REG        = 8'h02,
  parameter int unsigned POLL_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        i2c_done_i,
  input  logic [7:0]  i2c_rd_data_i,
  output logic [31:0] temp_config_data_o,
  output logic        i2c_start_o,
  output logic [15:0] temp_raw_o,
  output logic        temp_valid_o,
  output logic        sensor_ok_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [3:0] {
    IDLE, CFG_REQ, CFG_WAIT, MSB_REQ, MSB_WAIT, LSB_REQ, LSB_WAIT, UPDATE, PERIOD
  } state_e;

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_CYCLES);

  state_e        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          cfg_pend_q, cfg_pend_d;
  logic [31:0]   config_q, config_d;
  logic          start_q, start_d;
  logic [15:0]   raw_q, raw_d;
  logic          valid_q, valid_d;
  logic          ok_q, ok_d;
  logic [7:0]    msb_hold_q, msb_hold_d;
  logic [7:0]    lsb_hold_q, lsb_hold_d;
  logic          in_wait;
  logic          timeout;

  assign in_wait = (state_q == CFG_WAIT) || (state_q == MSB_WAIT) || (state_q == LSB_WAIT);

`ifdef TEMP_POLL_WDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wdog_q, wdog_d;
  logic [7:0]    err_q, err_d;
  logic          is_req;

  assign is_req  = (state_q == CFG_REQ) || (state_q == MSB_REQ) || (state_q == LSB_REQ);
  // A done arriving on the limit cycle wins, so the limit only fires without done.
  assign timeout = in_wait && !i2c_done_i && (wdog_q == WD_LAST);

  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if (is_req) wdog_d = '0;
    else if (in_wait && (wdog_q != WD_LAST)) wdog_d = wdog_q + WW'(1);
    if (timeout && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= '0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_cnt_o = err_q;
`else
  assign timeout   = 1'b0;
  assign err_cnt_o = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      poll_q     <= '0;
      cfg_pend_q <= 1'b0;
      config_q   <= '0;
      start_q    <= 1'b0;
      raw_q      <= '0;
      valid_q    <= 1'b0;
      ok_q       <= 1'b0;
      msb_hold_q <= '0;
      lsb_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      poll_q     <= poll_d;
      cfg_pend_q <= cfg_pend_d;
      config_q   <= config_d;
      start_q    <= start_d;
      raw_q      <= raw_d;
      valid_q    <= valid_d;
      ok_q       <= ok_d;
      msb_hold_q <= msb_hold_d;
      lsb_hold_q <= lsb_hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (enable_i) state_d = CFG_REQ;
      CFG_REQ:  state_d = CFG_WAIT;
      MSB_REQ:  state_d = MSB_WAIT;
      LSB_REQ:  state_d = LSB_WAIT;
      CFG_WAIT: if (i2c_done_i) state_d = MSB_REQ; else if (timeout) state_d = PERIOD;
      MSB_WAIT: if (i2c_done_i) state_d = LSB_REQ; else if (timeout) state_d = PERIOD;
      LSB_WAIT: if (i2c_done_i) state_d = UPDATE;  else if (timeout) state_d = PERIOD;
      UPDATE:   state_d = PERIOD;
      PERIOD: begin
        if (!enable_i) state_d = IDLE;
        else if (poll_q >= POLL_LAST) state_d = cfg_pend_q ? CFG_REQ : MSB_REQ;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Start is dropped on the done cycle itself so the controller never sees a relaunch request.
  always_comb begin
    config_d   = config_q;
    start_d    = in_wait && !i2c_done_i && !timeout;
    raw_d      = raw_q;
    valid_d    = 1'b0;
    ok_d       = ok_q;
    msb_hold_d = msb_hold_q;
    lsb_hold_d = lsb_hold_q;
    cfg_pend_d = cfg_pend_q;
    poll_d     = (poll_q == POLL_MAX) ? poll_q : poll_q + PW'(1);
    case (state_q)
      CFG_REQ: begin
        config_d   = {DEV_ADDR, 1'b0, CFG_REG, 8'h00, CFG_DATA};
        poll_d     = PW'(1);
        cfg_pend_d = 1'b0;
      end
      MSB_REQ: begin
        config_d = {DEV_ADDR, 1'b1, MSB_REG, 8'h00, 8'h00};
        poll_d   = PW'(1);
      end
      LSB_REQ:  config_d = {DEV_ADDR, 1'b1, LSB_REG, 8'h00, 8'h00};
      MSB_WAIT: if (i2c_done_i) msb_hold_d = i2c_rd_data_i;
      LSB_WAIT: if (i2c_done_i) lsb_hold_d = i2c_rd_data_i;
      default: ;
    endcase
    if (state_d == UPDATE) begin
      raw_d   = {msb_hold_q, lsb_hold_d};
      valid_d = 1'b1;
      ok_d    = 1'b1;
    end
    if (timeout) begin
      ok_d = 1'b0;
      if (state_q == CFG_WAIT) cfg_pend_d = 1'b1;
    end
  end

  assign temp_config_data_o = config_q;
  assign i2c_start_o        = start_q;
  assign temp_raw_o         = raw_q;
  assign temp_valid_o       = valid_q;
  assign sensor_ok_o        = ok_q;

endmodule

// File: tb/tb_temp_poll_seq.sv
// Self-checking bench for temp_poll_seq with a behavioural I2C controller model.
// Expectations follow the TEMP_POLL_WDOG_EN setting the design is built with.
module tb_temp_poll_seq;

  localparam int POLL = 1000;
  localparam int TMO  = 600;
  localparam int RESP = 300;
  localparam logic [31:0] CFG_WORD = 32'h9001_0060;
  localparam logic [31:0] MSB_WORD = 32'h9100_0000;
  localparam logic [31:0] LSB_WORD = 32'h9102_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        i2c_done = 1'b0;
  logic [7:0]  i2c_rd_data = 8'h00;
  logic [31:0] temp_config_data;
  logic        i2c_start;
  logic [15:0] temp_raw;
  logic        temp_valid;
  logic        sensor_ok;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  // Controller model state and observation log
  int          cyc = 0;
  int          validCnt = 0;
  int          validLat = -1;
  int          relaunchErr = 0;
  int          highRun = 0;
  int          lastRun = 0;
  int          cnt = 0;
  int          lsbRiseCnt = 0;
  int          lsbDoneCyc = 0;
  bit          busy = 1'b0;
  bit          muteCfg = 1'b0;
  bit          muteLsb = 1'b0;
  logic [7:0]  msbByte = 8'h19;
  logic [7:0]  lsbByte = 8'h80;
  logic [7:0]  regSel;
  logic [31:0] cmdQ[$];
  int          msbRiseQ[$];

  always #10 clk = ~clk;

  temp_poll_seq #(
    .POLL_CYCLES(POLL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable_i(enable),
    .i2c_done_i(i2c_done),
    .i2c_rd_data_i(i2c_rd_data),
    .temp_config_data_o(temp_config_data),
    .i2c_start_o(i2c_start),
    .temp_raw_o(temp_raw),
    .temp_valid_o(temp_valid),
    .sensor_ok_o(sensor_ok),
    .err_cnt_o(err_cnt)
  );

  // Controller: answers RESP cycles after start rises unless the addressed register is muted,
  // and aborts silently when start drops.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (temp_valid) begin
      validCnt = validCnt + 1;
      validLat = cyc - lsbDoneCyc;
    end
    if (i2c_done && i2c_start) relaunchErr = relaunchErr + 1;
    if (i2c_start) highRun = highRun + 1;
    else begin
      if (highRun != 0) lastRun = highRun;
      highRun = 0;
    end
    i2c_done = 1'b0;
    regSel = temp_config_data[23:16];
    if (!rst_n) busy = 1'b0;
    else if (i2c_start) begin
      if (!busy) begin
        busy = 1'b1;
        cnt = 0;
        cmdQ.push_back(temp_config_data);
        if (regSel == 8'h00) msbRiseQ.push_back(cyc);
        if (regSel == 8'h02) lsbRiseCnt = lsbRiseCnt + 1;
      end
      cnt = cnt + 1;
      if (cnt == RESP && !((regSel == 8'h01 && muteCfg) || (regSel == 8'h02 && muteLsb))) begin
        i2c_done = 1'b1;
        i2c_rd_data = (regSel == 8'h00) ? msbByte : (regSel == 8'h02) ? lsbByte : 8'h00;
        if (regSel == 8'h02) lsbDoneCyc = cyc;
        busy = 1'b0;
      end
    end else busy = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic rstn);
    enable = en;
    rst_n  = rstn;
  endtask

  task automatic waitValid(input int target, input string tag);
    for (int i = 0; i < 3000 && validCnt < target; i++) tick();
    checkOutput(tag, 32'(validCnt >= target), 32'd1);
  endtask

  task automatic waitCmd(input int target, input string tag);
    for (int i = 0; i < 2000 && cmdQ.size() < target; i++) tick();
    checkOutput(tag, 32'(cmdQ.size() >= target), 32'd1);
  endtask

  task automatic waitLsbRise(input int target, input string tag);
    for (int i = 0; i < 2500 && lsbRiseCnt < target; i++) tick();
    checkOutput(tag, 32'(lsbRiseCnt >= target), 32'd1);
  endtask

  task automatic waitStartLow(input string tag);
    for (int i = 0; i < 900 && i2c_start; i++) tick();
    checkOutput(tag, 32'(i2c_start), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cfg"},   temp_config_data, 32'h0);
    checkOutput({tag, "_start"}, 32'(i2c_start), 32'd0);
    checkOutput({tag, "_raw"},   32'(temp_raw), 32'd0);
    checkOutput({tag, "_valid"}, 32'(temp_valid), 32'd0);
    checkOutput({tag, "_ok"},    32'(sensor_ok), 32'd0);
    checkOutput({tag, "_err"},   32'(err_cnt), 32'd0);
  endtask

  initial begin
    int c0;
    int r0;
    logic [15:0] expRaw;
    logic [15:0] savedRaw;

    applyStimulus(1'b0, 1'b0);
    repeat (5) tick();
    checkResetOutputs("reset");

    // First sequence: config write, then the MSB/LSB read of a known sample
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1);
    waitCmd(1, "cfgIssued");
    checkOutput("cfgWord", cmdQ[0], CFG_WORD);
    waitValid(1, "firstValid");
    checkOutput("msbWord", cmdQ[1], MSB_WORD);
    checkOutput("lsbWord", cmdQ[2], LSB_WORD);
    checkOutput("firstRaw", 32'(temp_raw), 32'h1980);
    checkOutput("firstOk", 32'(sensor_ok), 32'd1);
    checkOutput("validLat", validLat, 32'd1);
    checkOutput("validHigh", 32'(temp_valid), 32'd1);
    tick();
    checkOutput("validPulse", 32'(temp_valid), 32'd0);
    checkOutput("validCount", validCnt, 32'd1);

    // Steady-state polling with random sensor bytes
    for (int k = 0; k < 3; k++) begin
      msbByte = 8'($urandom);
      lsbByte = 8'($urandom);
      expRaw = {msbByte, lsbByte};
      waitValid(validCnt + 1, "steadyValid");
      checkOutput("steadyRaw", 32'(temp_raw), 32'(expRaw));
      checkOutput("steadyLat", validLat, 32'd1);
    end
    checkOutput("pollSpacing1", msbRiseQ[2] - msbRiseQ[1], POLL);
    checkOutput("pollSpacing2", msbRiseQ[3] - msbRiseQ[2], POLL);
    checkOutput("noRelaunch", relaunchErr, 32'd0);
    checkOutput("noErrors", 32'(err_cnt), 32'd0);

`ifdef TEMP_POLL_WDOG_EN
    // LSB read never answered: watchdog drops start, keeps the last sample
    savedRaw = temp_raw;
    r0 = validCnt;
    muteLsb = 1'b1;
    waitLsbRise(lsbRiseCnt + 1, "lsbMuteRise");
    waitStartLow("lsbTimeoutDrop");
    tick();
    checkOutput("lsbTimeoutLen", 32'(lastRun >= TMO - 2 && lastRun <= TMO + 1), 32'd1);
    checkOutput("lsbTimeoutErr", 32'(err_cnt), 32'd1);
    checkOutput("lsbTimeoutOk", 32'(sensor_ok), 32'd0);
    checkOutput("lsbTimeoutRaw", 32'(temp_raw), 32'(savedRaw));
    checkOutput("lsbTimeoutNoValid", validCnt, r0);
    muteLsb = 1'b0;
    msbByte = 8'($urandom);
    lsbByte = 8'($urandom);
    expRaw = {msbByte, lsbByte};
    c0 = cmdQ.size();
    waitCmd(c0 + 1, "retryIssued");
    checkOutput("retryIsMsb", cmdQ[c0], MSB_WORD);
    waitValid(r0 + 1, "retryValid");
    checkOutput("retryRaw", 32'(temp_raw), 32'(expRaw));
    checkOutput("retryOk", 32'(sensor_ok), 32'd1);
    checkOutput("retryErr", 32'(err_cnt), 32'd1);
`endif

    // Disable in the middle of an MSB read: the sample still completes, then the sequencer idles
    msbByte = 8'($urandom);
    lsbByte = 8'($urandom);
    expRaw = {msbByte, lsbByte};
    r0 = msbRiseQ.size();
    for (int i = 0; i < 1500 && msbRiseQ.size() == r0; i++) tick();
    checkOutput("msbWaitReached", 32'(msbRiseQ.size() > r0), 32'd1);
    repeat (20) tick();
    applyStimulus(1'b0, 1'b1);
    waitValid(validCnt + 1, "disableValid");
    checkOutput("disableRaw", 32'(temp_raw), 32'(expRaw));
    c0 = cmdQ.size();
    repeat (2500) tick();
    checkOutput("idleNoCmd", cmdQ.size(), c0);
    checkOutput("idleStart", 32'(i2c_start), 32'd0);

`ifdef TEMP_POLL_WDOG_EN
    // Re-enable with the config write unanswered: the next poll repeats the config write
    muteCfg = 1'b1;
    applyStimulus(1'b1, 1'b1);
    waitCmd(c0 + 1, "reenCmd");
    checkOutput("reenCfgFirst", cmdQ[c0], CFG_WORD);
    waitStartLow("cfgTimeoutDrop");
    tick();
    checkOutput("cfgTimeoutErr", 32'(err_cnt), 32'd2);
    checkOutput("cfgTimeoutOk", 32'(sensor_ok), 32'd0);
    muteCfg = 1'b0;
    waitCmd(c0 + 2, "cfgRetryCmd");
    checkOutput("cfgRetryWord", cmdQ[c0 + 1], CFG_WORD);
    waitValid(validCnt + 1, "cfgRetryValid");
    checkOutput("cfgRetryOk", 32'(sensor_ok), 32'd1);
    checkOutput("cfgRetryErr", 32'(err_cnt), 32'd2);
    // Reset lands in the middle of an answered LSB read
    waitLsbRise(lsbRiseCnt + 1, "rstLsbRise");
    repeat (50) tick();
`else
    applyStimulus(1'b1, 1'b1);
    waitCmd(c0 + 1, "reenCmd");
    checkOutput("reenCfgFirst", cmdQ[c0], CFG_WORD);
    waitValid(validCnt + 1, "reenValid");
    checkOutput("reenOk", 32'(sensor_ok), 32'd1);
    // Without the watchdog an unanswered LSB read holds start indefinitely
    muteLsb = 1'b1;
    waitLsbRise(lsbRiseCnt + 1, "noWdogLsbRise");
    repeat (TMO + 100) tick();
    checkOutput("noWdogStart", 32'(i2c_start), 32'd1);
    checkOutput("noWdogRun", 32'(highRun > TMO), 32'd1);
    checkOutput("noWdogErr", 32'(err_cnt), 32'd0);
    checkOutput("noWdogOk", 32'(sensor_ok), 32'd1);
    muteLsb = 1'b0;
`endif

    // Asynchronous reset during LSB_WAIT clears every output before the next clock edge
    applyStimulus(1'b1, 1'b0);
    #1;
    checkResetOutputs("asyncRst");
    repeat (3) tick();
    c0 = cmdQ.size();
    applyStimulus(1'b1, 1'b1);
    waitCmd(c0 + 1, "postRstCmd");
    checkOutput("postRstCfg", cmdQ[c0], CFG_WORD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
